// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the FWFT output stage.
//   DW_DEF / DEPTH_DEF / RD_LAT_DEF : default data width, buffer depth and
//                                     RAM read latency.
//   cnt_width()                     : width of a counter that must hold
//                                     0..depth inclusive.
package fifo_pkg;

   localparam int DW_DEF     = 8;
   localparam int DEPTH_DEF  = 4;
   localparam int RD_LAT_DEF = 3;

   // A counter that reaches 'depth' itself (full) needs one bit beyond the
   // index width.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fwft_buf.sv
// fwft_buf: small synchronous circular buffer with push/pop and occupancy.
//   clk, rst  : clock, asynchronous active-high reset (indices and level only)
//   push, din : write din at the write index (dropped when full and no pop)
//   pop       : advance the read index (ignored when empty)
//   dout      : head entry, valid while level != 0
//   level     : number of stored entries, 0..DEPTH
//   drop      : push rejected this cycle because the buffer was full
module fwft_buf
   import fifo_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [DW-1:0]                din,
   output logic [DW-1:0]                dout,
   output logic [cnt_width(DEPTH)-1:0]  level,
   output logic                         drop
);

   localparam int IW = $clog2(DEPTH);
   localparam int LW = cnt_width(DEPTH);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   // Storage is deliberately not reset; only the bookkeeping is.
   logic [DW-1:0] mem [DEPTH];

   logic [IW-1:0] wr_idx_q, wr_idx_d;
   logic [IW-1:0] rd_idx_q, rd_idx_d;
   logic [LW-1:0] level_q, level_d;
   logic          accept;
   logic          pop_ok;

   // When full, a same-cycle pop frees the head slot, which is exactly the
   // slot the write index points at, so the push can still be taken.
   assign accept = push & ((level_q != FULL_LVL) | pop_ok);
   assign pop_ok = pop & (level_q != '0);
   assign drop   = push & ~accept;

   always_comb begin
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      level_d  = level_q;
      // DEPTH is a power of two, so plain index increments wrap correctly.
      if (accept) wr_idx_d = wr_idx_q + 1'b1;
      if (pop_ok) rd_idx_d = rd_idx_q + 1'b1;
      if (accept && !pop_ok)      level_d = level_q + 1'b1;
      else if (!accept && pop_ok) level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         level_q  <= '0;
      end else begin
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_idx_q] <= din;
   end

   // Head must be visible in the same cycle it becomes valid, so the read
   // is asynchronous from the small distributed array.
   assign dout  = mem[rd_idx_q];
   assign level = level_q;

endmodule

// File: rtl/fifo_fwft_out.sv
// fifo_fwft_out: first-word-fall-through output stage for a FIFO whose RAM
// has RD_LAT cycles of read latency. Issues reads only when the output
// buffer is guaranteed to have room for every word already requested.
//   rclk, rrst          : clock, asynchronous active-high reset
//   rempty              : registered empty flag from the read-pointer stage
//   ren                 : read request to the read-pointer stage
//   mem_dout/dout_valid : RAM read data and its single-cycle strobe
//   m_valid/m_ready/m_data : FWFT consumer handshake
//   level               : words held in the output buffer
//   ovf_err             : sticky, a word arrived while the buffer was full
module fifo_fwft_out
   import fifo_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic                         rclk,
   input  logic                         rrst,
   input  logic                         rempty,
   output logic                         ren,
   input  logic [DW-1:0]                mem_dout,
   input  logic                         dout_valid,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [DW-1:0]                m_data,
   output logic [cnt_width(DEPTH)-1:0]  level,
   output logic                         ovf_err
);

   localparam int CW = cnt_width(DEPTH);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [CW-1:0] inflight_q, inflight_d;
   logic          ovf_q, ovf_d;
   logic          fire;
   logic          pop;
   logic          drop;
   logic [CW:0]   credit_sum;

   assign pop  = m_valid & m_ready;
   assign fire = ren & ~rempty;

   // Words already buffered plus words still in the RAM pipeline, minus the
   // one leaving this cycle, must stay below DEPTH for a new read to be safe.
   // One extra bit keeps the sum from wrapping.
   assign credit_sum = {1'b0, level} + {1'b0, inflight_q} - {{CW{1'b0}}, pop};
   // Gated by rrst so the request drops the instant reset is asserted.
   assign ren = ~rrst & ~rempty & (credit_sum < DEPTH_C);

   always_comb begin
      inflight_d = inflight_q;
      if (fire && !dout_valid) begin
         inflight_d = inflight_q + 1'b1;
      end else if (!fire && dout_valid && (inflight_q != '0)) begin
         // Stray strobes after a reset must not underflow the counter.
         inflight_d = inflight_q - 1'b1;
      end
   end

   assign ovf_d = ovf_q | drop;

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         inflight_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         ovf_q      <= ovf_d;
      end
   end

   fwft_buf #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk   (rclk),
      .rst   (rrst),
      .push  (dout_valid),
      .pop   (pop),
      .din   (mem_dout),
      .dout  (m_data),
      .level (level),
      .drop  (drop)
   );

   assign m_valid = (level != '0);
   assign ovf_err = ovf_q;

endmodule

// File: tb/tb_fifo_fwft_out.sv
module tb_fifo_fwft_out;

   localparam int DW     = 8;
   localparam int DEPTH  = 4;
   localparam int RD_LAT = 3;

   logic          rclk = 1'b0;
   logic          rrst;
   logic          rempty;
   logic          ren;
   logic [DW-1:0] mem_dout;
   logic          dout_valid;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [2:0]    level;
   logic          ovf_err;

   int passed = 0;
   int total  = 0;

   // Upstream read-pointer/RAM model: each fire returns a sequence number
   // RD_LAT cycles later. force_dv injects an extra strobe with force_data.
   logic              force_dv;
   logic [DW-1:0]     force_data;
   logic [DW-1:0]     src_cnt = '0;
   logic [RD_LAT-1:0] pipe_v;
   logic [DW-1:0]     pipe_d [RD_LAT];

   always #5 rclk = ~rclk;

   always @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         pipe_v <= '0;
      end else begin
         pipe_v    <= {pipe_v[RD_LAT-2:0], ren & ~rempty};
         pipe_d[0] <= src_cnt;
         for (int i = 1; i < RD_LAT; i++) pipe_d[i] <= pipe_d[i-1];
         if (ren && !rempty) src_cnt <= src_cnt + 1'b1;
      end
   end

   assign dout_valid = pipe_v[RD_LAT-1] | force_dv;
   assign mem_dout   = force_dv ? force_data : pipe_d[RD_LAT-1];

   fifo_fwft_out #(
      .DW     (DW),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT)
   ) dut (
      .rclk       (rclk),
      .rrst       (rrst),
      .rempty     (rempty),
      .ren        (ren),
      .mem_dout   (mem_dout),
      .dout_valid (dout_valid),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .level      (level),
      .ovf_err    (ovf_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge rclk);
      #2;
   endtask

   logic [DW-1:0] exp_d;
   logic [DW-1:0] base;
   int            fires;

   initial begin
      rrst = 1'b1; rempty = 1'b1; m_ready = 1'b0;
      force_dv = 1'b0; force_data = '0;

      // Reset state
      tick(); tick();
      #1;
      check("rst_level",   level,   0);
      check("rst_m_valid", m_valid, 0);
      check("rst_ren",     ren,     0);
      check("rst_ovf",     ovf_err, 0);
      tick();
      rrst = 1'b0;

      // Idle then stream: ren on cycle 0, first word on cycle 4, then 1/cycle
      tick();
      #1 check("idle_ren", ren, 0);
      tick();
      rempty = 1'b0; m_ready = 1'b1;
      #1 check("c0_ren", ren, 1);
      for (int k = 1; k < 10; k++) begin
         tick();
         #1;
         if (k < RD_LAT + 1) begin
            check("lat_no_valid", m_valid, 0);
         end else begin
            check("stream_valid", m_valid, 1);
            check("stream_data",  m_data,  k - 4);
         end
      end
      tick();
      rempty = 1'b1;
      exp_d = 8'd6;
      repeat (8) begin
         #1;
         if (m_valid) begin
            check("tail_data", m_data, exp_d);
            exp_d = exp_d + 1'b1;
         end
         tick();
      end
      #1;
      check("tail_count", exp_d, 10);
      check("tail_level", level, 0);

      // Back-pressure: exactly DEPTH fires, level settles at DEPTH
      tick();
      rrst = 1'b1; m_ready = 1'b0;
      tick();
      rrst = 1'b0;
      tick();
      base = src_cnt;
      rempty = 1'b0;
      fires = 0;
      repeat (10) begin
         #1;
         if (ren && !rempty) fires++;
         tick();
      end
      #1;
      check("bp_fires",    fires,          4);
      check("bp_ren",      ren,            0);
      check("bp_level",    level,          4);
      check("bp_inflight", dut.inflight_q, 0);
      check("bp_ovf",      ovf_err,        0);
      check("bp_head",     m_data,         base);

      // One pop from full: ren re-asserts in the pop cycle, refill after 4
      tick();
      m_ready = 1'b1;
      #1;
      check("pop_ren",  ren,    1);
      check("pop_data", m_data, base);
      tick();
      m_ready = 1'b0;
      #1;
      check("pop_level1", level,  3);
      check("pop_ren_off", ren,   0);
      check("pop_head",   m_data, base + 8'd1);
      tick(); tick();
      #1 check("pop_level3", level, 3);
      tick();
      #1 check("pop_refill", level, 4);

      // Forced strobe while full: dropped, sticky overflow
      tick();
      force_dv = 1'b1; force_data = 8'hAA;
      tick();
      force_dv = 1'b0;
      #1;
      check("ovf_level",    level,          4);
      check("ovf_flag",     ovf_err,        1);
      check("ovf_head",     m_data,         base + 8'd1);
      check("ovf_inflight", dut.inflight_q, 0);
      tick(); tick(); tick();
      #1 check("ovf_sticky", ovf_err, 1);
      tick();
      rempty = 1'b1; m_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("ovf_drain_valid", m_valid, 1);
         check("ovf_drain_data",  m_data,  base + 8'd1 + k[7:0]);
         tick();
      end
      m_ready = 1'b0;
      #1;
      check("ovf_drained", level,   0);
      check("ovf_kept",    ovf_err, 1);

      // Async reset mid-operation, then a stray strobe
      tick();
      rempty = 1'b0;
      repeat (5) tick();
      #1;
      check("mid_level",    level,          2);
      check("mid_inflight", dut.inflight_q, 2);
      #1 rrst = 1'b1;
      #1;
      check("arst_level",    level,          0);
      check("arst_m_valid",  m_valid,        0);
      check("arst_ren",      ren,            0);
      check("arst_ovf",      ovf_err,        0);
      check("arst_inflight", dut.inflight_q, 0);
      tick();
      rrst = 1'b0; rempty = 1'b1;
      tick();
      force_dv = 1'b1; force_data = 8'h5A;
      tick();
      force_dv = 1'b0;
      #1;
      check("stray_level",    level,          1);
      check("stray_valid",    m_valid,        1);
      check("stray_data",     m_data,         8'h5A);
      check("stray_inflight", dut.inflight_q, 0);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      #1;
      check("stray_pop_level", level,          0);
      check("stray_pop_infl",  dut.inflight_q, 0);

      // Random back-pressure and empty: order preserved, no loss
      tick();
      exp_d = src_cnt;
      repeat (3000) begin
         rempty  = ($urandom_range(0, 3) == 0);
         m_ready = $urandom_range(0, 1) != 0;
         #1;
         if (m_valid && m_ready) begin
            check("rand_data", m_data, exp_d);
            exp_d = exp_d + 1'b1;
         end
         tick();
      end
      rempty = 1'b1; m_ready = 1'b1;
      repeat (20) begin
         #1;
         if (m_valid) begin
            check("rand_data", m_data, exp_d);
            exp_d = exp_d + 1'b1;
         end
         tick();
      end
      #1;
      check("rand_all_out", exp_d,   src_cnt);
      check("rand_level",   level,   0);
      check("rand_ovf",     ovf_err, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
